// File: rtl/sort_engine.sv
// Frame sorter: loads up to N words, runs N odd-even transposition phases, streams the frame out ascending.
// Define SORT_SIGNED_EN to compare words as two's-complement instead of unsigned.
module sort_cas #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic             swap_o
);
  // Strict compare keeps equal words in place, so the sort is stable.
`ifdef SORT_SIGNED_EN
  assign swap_o = $signed(lo_i) > $signed(hi_i);
`else
  assign swap_o = lo_i > hi_i;
`endif
endmodule

module sort_engine #(
  parameter int WIDTH = 32,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
`ifdef SORT_SIGNED_EN
  localparam logic [WIDTH-1:0] PADMAX = {1'b0, {(WIDTH-1){1'b1}}};
`else
  localparam logic [WIDTH-1:0] PADMAX = {WIDTH{1'b1}};
`endif

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_e;

  state_e                       state_q, state_d;
  logic [N-1:0][WIDTH-1:0]      data_q, data_d;
  logic [N-1:0][WIDTH-1:0]      sorted;
  logic [CW-1:0]                count_q, count_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                phase_q, phase_d;
  logic [N-2:0]                 swap, act;

  // One compare/swap lane per adjacent pair; even phases use even pairs, odd phases odd pairs.
  for (genvar k = 0; k < N-1; k++) begin : g_cas
    sort_cas #(.WIDTH(WIDTH)) u_cas (
      .lo_i   (data_q[k]),
      .hi_i   (data_q[k+1]),
      .swap_o (swap[k])
    );
    assign act[k] = swap[k] & (phase_q[0] == 1'(k % 2));
  end

  for (genvar j = 0; j < N; j++) begin : g_slot
    if (j == 0) begin : g_first
      assign sorted[j] = act[j] ? data_q[j+1] : data_q[j];
    end else if (j == N-1) begin : g_last
      assign sorted[j] = act[j-1] ? data_q[j-1] : data_q[j];
    end else begin : g_mid
      assign sorted[j] = act[j]   ? data_q[j+1] :
                         act[j-1] ? data_q[j-1] : data_q[j];
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? data_q[idx_q] : '0;
  assign out_last  = out_valid && (CW'(idx_q) == count_q - CW'(1));
  assign busy      = (state_q != S_LOAD);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    count_d  = count_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    in_ready = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d[count_q[IW-1:0]] = in_data;
          count_d = count_q + CW'(1);
          if (in_last || count_q == CW'(N-1)) begin
            state_d = S_SORT;
            phase_d = '0;
            // Unused slots sort to the end and are never streamed out.
            for (int i = 0; i < N; i++)
              if (CW'(i) > count_q) data_d[i] = PADMAX;
          end
        end
      end
      S_SORT: begin
        data_d  = sorted;
        phase_d = phase_q + IW'(1);
        if (phase_q == IW'(N-1)) begin
          state_d = S_OUT;
          idx_d   = '0;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = S_LOAD;
            count_d = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      data_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end
endmodule
